// File: rtl/frame_swap_ctrl.sv
// Double-buffered frame store: renderer fills the back bank, video timing scans the
// front bank with integer upscaling, clearing each pixel behind the scan before a swap.
module frame_swap_ctrl #(
  parameter int               FB_W       = 320,
  parameter int               FB_H       = 180,
  parameter int               PIX_W      = 16,
  parameter int               SCALE_LOG2 = 0,
  parameter int               H_ACTIVE   = 1280,
  parameter int               V_ACTIVE   = 720,
  parameter int               HC_W       = 11,
  parameter int               VC_W       = 10,
  parameter bit               CLEAR_EN   = 1'b1,
  parameter logic [PIX_W-1:0] CLEAR_VAL  = '0,
  localparam int              NPIX       = FB_W * FB_H,
  localparam int              AW         = $clog2(NPIX)
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             wr_valid_in,
  input  logic [AW-1:0]    wr_addr_in,
  input  logic [PIX_W-1:0] wr_data_in,
  output logic             wr_ready_out,
  input  logic             frame_done_in,
  input  logic [HC_W-1:0]  hcount_in,
  input  logic [VC_W-1:0]  vcount_in,
  output logic [PIX_W-1:0] pixel_out,
  output logic             pixel_valid_out,
  output logic             swap_out,
  output logic             front_buf_out,
  output logic             pending_out
);

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PENDING = 1'b1
  } state_e;

  localparam logic [HC_W-1:0] HMASK = HC_W'((32'd1 << SCALE_LOG2) - 32'd1);
  localparam logic [VC_W-1:0] VMASK = VC_W'((32'd1 << SCALE_LOG2) - 32'd1);

  state_e state_q, state_d;
  logic   front_q, front_d;
  logic   arm_q, arm_d;
  logic   ready_q, ready_d;
  logic   swap_q, swap_d;

  logic [HC_W-1:0] sx_s;
  logic [VC_W-1:0] sy_s;
  logic [AW-1:0]   addr_s;
  logic            in_win_s;
  logic            last_s;
  logic            frame_start_s;
  logic            swap_pt_s;
  logic            pend_eff_s;
  logic            arm_eff_s;
  logic            swap_go_s;
  logic            clr_s;

  logic [AW-1:0]   s1_addr_q;
  logic            s1_win_q;
  logic            s1_bank_q;
  logic            s1_clr_q;
  logic            s2_win_q;
  logic            s2_bank_q;

  logic [PIX_W-1:0] mem0 [NPIX] = '{default: CLEAR_VAL};
  logic [PIX_W-1:0] mem1 [NPIX] = '{default: CLEAR_VAL};
  logic [PIX_W-1:0] rd0_q, rd1_q;

  logic             wr_fire_s;
  logic             ren0_s, ren1_s, clr0_s, clr1_s;
  logic             we0_s, we1_s;
  logic [AW-1:0]    wa0_s, wa1_s;
  logic [PIX_W-1:0] wd0_s, wd1_s;

  // Display-to-source mapping and scan-position decodes
  assign sx_s          = hcount_in >> SCALE_LOG2;
  assign sy_s          = vcount_in >> SCALE_LOG2;
  assign in_win_s      = (int'(sx_s) < FB_W) && (int'(sy_s) < FB_H);
  assign addr_s        = AW'(sx_s) + AW'(FB_W) * AW'(sy_s);
  assign last_s        = ((hcount_in & HMASK) == HMASK) && ((vcount_in & VMASK) == VMASK);
  assign frame_start_s = (hcount_in == '0) && (vcount_in == '0);
  assign swap_pt_s     = (hcount_in == HC_W'(H_ACTIVE - 1)) && (vcount_in == VC_W'(V_ACTIVE - 1));

  // A frame_done arriving on the frame-start cycle already arms clearing for this frame,
  // so the very first pixel of the frame is cleared too.
  assign pend_eff_s = (state_q == ST_PENDING) || frame_done_in;
  assign arm_eff_s  = frame_start_s ? pend_eff_s : arm_q;
  assign swap_go_s  = swap_pt_s && (CLEAR_EN ? ((state_q == ST_PENDING) && arm_q) : pend_eff_s);
  assign clr_s      = CLEAR_EN && arm_eff_s && in_win_s && last_s;

  // Swap FSM next-state and registered-output decode
  always_comb begin
    state_d = state_q;
    front_d = front_q;
    arm_d   = arm_q;
    swap_d  = 1'b0;
    if (swap_go_s) begin
      state_d = ST_IDLE;
      front_d = ~front_q;
      arm_d   = 1'b0;
      swap_d  = 1'b1;
    end else begin
      arm_d = arm_eff_s;
      if (frame_done_in) begin
        state_d = ST_PENDING;
      end else begin
        state_d = state_q;
      end
    end
    ready_d = (state_d == ST_IDLE);
  end

  // Swap FSM and control registers
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= ST_IDLE;
      front_q <= 1'b0;
      arm_q   <= 1'b0;
      ready_q <= 1'b1;
      swap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      front_q <= front_d;
      arm_q   <= arm_d;
      ready_q <= ready_d;
      swap_q  <= swap_d;
    end
  end

  // Read pipeline: stage 1 captures address/window/bank/clear, stage 2 tracks the data beat
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      s1_addr_q <= '0;
      s1_win_q  <= 1'b0;
      s1_bank_q <= 1'b0;
      s1_clr_q  <= 1'b0;
      s2_win_q  <= 1'b0;
      s2_bank_q <= 1'b0;
    end else begin
      s1_addr_q <= in_win_s ? addr_s : '0;
      s1_win_q  <= in_win_s;
      s1_bank_q <= front_q;
      s1_clr_q  <= clr_s;
      s2_win_q  <= s1_win_q;
      s2_bank_q <= s1_bank_q;
    end
  end

  // Port A arbitration: renderer writes target the back bank, clears the bank that was read.
  // A renderer write wins if both hit the same bank on one cycle.
  assign wr_fire_s = wr_valid_in && ready_q && (int'(wr_addr_in) < NPIX);
  assign ren0_s    = wr_fire_s && front_q;
  assign ren1_s    = wr_fire_s && !front_q;
  assign clr0_s    = s1_clr_q && !s1_bank_q;
  assign clr1_s    = s1_clr_q && s1_bank_q;
  assign we0_s     = ren0_s || clr0_s;
  assign we1_s     = ren1_s || clr1_s;
  assign wa0_s     = ren0_s ? wr_addr_in : s1_addr_q;
  assign wa1_s     = ren1_s ? wr_addr_in : s1_addr_q;
  assign wd0_s     = ren0_s ? wr_data_in : CLEAR_VAL;
  assign wd1_s     = ren1_s ? wr_data_in : CLEAR_VAL;

  // Bank 0 RAM, read-first
  always_ff @(posedge clk_in) begin
    if (we0_s) begin
      mem0[wa0_s] <= wd0_s;
    end
    rd0_q <= mem0[s1_addr_q];
  end

  // Bank 1 RAM, read-first
  always_ff @(posedge clk_in) begin
    if (we1_s) begin
      mem1[wa1_s] <= wd1_s;
    end
    rd1_q <= mem1[s1_addr_q];
  end

  assign pixel_out       = s2_win_q ? (s2_bank_q ? rd1_q : rd0_q) : '0;
  assign pixel_valid_out = s2_win_q;
  assign wr_ready_out    = ready_q;
  assign swap_out        = swap_q;
  assign front_buf_out   = front_q;
  assign pending_out     = (state_q == ST_PENDING);

endmodule

// File: tb/tb_frame_swap_ctrl.sv
// Directed scoreboard bench for frame_swap_ctrl on a small 16x8 display with three
// instances: 1x scale with clearing, 2x scale with clearing, and 1x without clearing.
module tb_frame_swap_ctrl;

  localparam int H_TOT = 20;
  localparam int V_TOT = 10;

  typedef struct {
    int          due;
    int          dut;
    logic [15:0] pix;
    logic        vld;
    string       tag;
  } xp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  hc;
  logic [3:0]  vc;
  logic [2:0]  wv, fd, rdy, swp, fb, pend, pvld;
  logic [4:0]  wa [3];
  logic [15:0] wd [3];
  logic [15:0] pix [3];

  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  xp_t sb [$];

  always #5 clk = ~clk;

  frame_swap_ctrl #(.FB_W(6), .FB_H(4), .PIX_W(16), .SCALE_LOG2(0), .H_ACTIVE(16), .V_ACTIVE(8),
                    .HC_W(5), .VC_W(4), .CLEAR_EN(1'b1), .CLEAR_VAL(16'h0000)) u0 (
    .clk_in(clk), .rst_n_in(rst_n), .wr_valid_in(wv[0]), .wr_addr_in(wa[0]), .wr_data_in(wd[0]),
    .wr_ready_out(rdy[0]), .frame_done_in(fd[0]), .hcount_in(hc), .vcount_in(vc),
    .pixel_out(pix[0]), .pixel_valid_out(pvld[0]), .swap_out(swp[0]), .front_buf_out(fb[0]),
    .pending_out(pend[0]));

  frame_swap_ctrl #(.FB_W(6), .FB_H(4), .PIX_W(16), .SCALE_LOG2(1), .H_ACTIVE(16), .V_ACTIVE(8),
                    .HC_W(5), .VC_W(4), .CLEAR_EN(1'b1), .CLEAR_VAL(16'h0000)) u1 (
    .clk_in(clk), .rst_n_in(rst_n), .wr_valid_in(wv[1]), .wr_addr_in(wa[1]), .wr_data_in(wd[1]),
    .wr_ready_out(rdy[1]), .frame_done_in(fd[1]), .hcount_in(hc), .vcount_in(vc),
    .pixel_out(pix[1]), .pixel_valid_out(pvld[1]), .swap_out(swp[1]), .front_buf_out(fb[1]),
    .pending_out(pend[1]));

  frame_swap_ctrl #(.FB_W(6), .FB_H(4), .PIX_W(16), .SCALE_LOG2(0), .H_ACTIVE(16), .V_ACTIVE(8),
                    .HC_W(5), .VC_W(4), .CLEAR_EN(1'b0), .CLEAR_VAL(16'h0000)) u2 (
    .clk_in(clk), .rst_n_in(rst_n), .wr_valid_in(wv[2]), .wr_addr_in(wa[2]), .wr_data_in(wd[2]),
    .wr_ready_out(rdy[2]), .frame_done_in(fd[2]), .hcount_in(hc), .vcount_in(vc),
    .pixel_out(pix[2]), .pixel_valid_out(pvld[2]), .swap_out(swp[2]), .front_buf_out(fb[2]),
    .pending_out(pend[2]));

  task automatic chk_bit(input string tag, input logic obs, input logic req);
    checks++;
    assert (obs === req) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, req);
    end
  endtask

  task automatic chk_word(input string tag, input logic [15:0] obs, input logic [15:0] req);
    checks++;
    assert (obs === req) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, req);
    end
  endtask

  task automatic chk_st(input int d, input logic sw, input logic f, input logic pd, input logic r,
                        input string tag);
    chk_bit({tag, "_swap"}, swp[d], sw);
    chk_bit({tag, "_front"}, fb[d], f);
    chk_bit({tag, "_pending"}, pend[d], pd);
    chk_bit({tag, "_ready"}, rdy[d], r);
  endtask

  // Pixel for the scan position driven now is due two cycles later.
  task automatic xp(input int d, input logic [15:0] p, input logic v, input string tag);
    xp_t e;
    e.due = cyc + 2;
    e.dut = d;
    e.pix = p;
    e.vld = v;
    e.tag = tag;
    sb.push_back(e);
  endtask

  // One clock: retire due scoreboard entries, drop one-cycle pulses, advance video timing.
  task automatic step();
    xp_t e;
    @(posedge clk);
    #1;
    cyc++;
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      chk_word({e.tag, "_pix"}, pix[e.dut], e.pix);
      chk_bit({e.tag, "_vld"}, pvld[e.dut], e.vld);
    end
    wv = 3'b000;
    fd = 3'b000;
    if (int'(hc) == H_TOT - 1) begin
      hc = 5'd0;
      vc = (int'(vc) == V_TOT - 1) ? 4'd0 : vc + 4'd1;
    end else begin
      hc = hc + 5'd1;
    end
  endtask

  task automatic goto(input int h, input int v);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!(int'(hc) == h && int'(vc) == v) && n < 2 * H_TOT * V_TOT);
    checks++;
    assert (int'(hc) == h && int'(vc) == v) else begin
      errors++;
      $error("FAIL goto observed=%0d,%0d expected=%0d,%0d", hc, vc, h, v);
    end
  endtask

  task automatic wr(input int d, input logic [4:0] a, input logic [15:0] data);
    wv[d] = 1'b1;
    wa[d] = a;
    wd[d] = data;
  endtask

  initial begin
    rst_n = 1'b0;
    hc = 5'd0;
    vc = 4'd0;
    wv = 3'b000;
    fd = 3'b000;
    for (int i = 0; i < 3; i++) begin
      wa[i] = 5'd0;
      wd[i] = 16'h0000;
    end
    repeat (5) step();
    for (int d = 0; d < 3; d++) begin
      chk_st(d, 1'b0, 1'b0, 1'b0, 1'b1, "reset");
      chk_word("reset_pix", pix[d], 16'h0000);
      chk_bit("reset_vld", pvld[d], 1'b0);
    end
    rst_n = 1'b1;
    goto(0, 0);

    // Frame 0: u0/u1 load the back bank and raise frame_done; u2 swaps on the swap-point cycle
    goto(1, 0); wr(2, 5'd2, 16'h1111);
    goto(2, 2); wr(0, 5'd24, 16'h1234);
    goto(3, 2); wr(0, 5'd0, 16'hF800); fd[0] = 1'b1; wr(1, 5'd1, 16'h07E0); fd[1] = 1'b1;
    goto(4, 2);
    chk_st(0, 1'b0, 1'b0, 1'b1, 1'b0, "f0_u0_pend");
    chk_st(1, 1'b0, 1'b0, 1'b1, 1'b0, "f0_u1_pend");
    wr(0, 5'd5, 16'h001F);
    goto(15, 7); fd[2] = 1'b1;
    goto(16, 7);
    chk_st(2, 1'b1, 1'b1, 1'b0, 1'b1, "f0_u2_swap");
    chk_st(0, 1'b0, 1'b0, 1'b1, 1'b0, "f0_u0_noswap");

    // Frame 1: clearing armed for u0/u1, all three swap at the end
    goto(0, 0); xp(0, 16'h0000, 1'b1, "f1_u0_00");
    goto(2, 0); xp(2, 16'h1111, 1'b1, "f1_u2_20");
    goto(1, 1); wr(2, 5'd3, 16'h2222);
    goto(3, 2); fd[2] = 1'b1;
    goto(16, 7);
    chk_st(0, 1'b1, 1'b1, 1'b0, 1'b1, "f1_u0_swap");
    chk_st(1, 1'b1, 1'b1, 1'b0, 1'b1, "f1_u1_swap");
    chk_st(2, 1'b1, 1'b0, 0, 1'b1, "f1_u2_swap");

    // Frame 2: new front contents, upscale, window edges, backpressured write absent
    goto(0, 0);  xp(0, 16'hF800, 1'b1, "f2_u0_00");
    goto(2, 0);  xp(1, 16'h07E0, 1'b1, "f2_u1_20"); xp(2, 16'h0000, 1'b1, "f2_u2_20");
    goto(3, 0);  xp(1, 16'h07E0, 1'b1, "f2_u1_30"); xp(2, 16'h2222, 1'b1, "f2_u2_30");
    goto(4, 0);  xp(1, 16'h0000, 1'b1, "f2_u1_40");
    goto(5, 0);  xp(0, 16'h0000, 1'b1, "f2_u0_bp");
    goto(6, 0);  xp(0, 16'h0000, 1'b0, "f2_u0_winx");
    goto(12, 0); xp(1, 16'h0000, 1'b0, "f2_u1_winx");
    goto(1, 1);  wr(0, 5'd7, 16'h0ABC);
    goto(2, 1);  xp(1, 16'h07E0, 1'b1, "f2_u1_21");
    goto(3, 1);  xp(1, 16'h07E0, 1'b1, "f2_u1_31");
    goto(3, 2);  fd[0] = 1'b1; fd[1] = 1'b1;
    goto(5, 3);  xp(0, 16'h0000, 1'b1, "f2_u0_53");
    goto(0, 4);  xp(0, 16'h0000, 1'b0, "f2_u0_winy");
    goto(15, 7); fd[2] = 1'b1;
    goto(16, 7);
    chk_st(2, 1'b1, 1'b1, 1'b0, 1'b1, "f2_u2_swap");
    chk_st(0, 1'b0, 1'b1, 1'b1, 1'b0, "f2_u0_wait");

    // Frame 3: armed; pixels read once more before being cleared
    goto(0, 0);  xp(0, 16'hF800, 1'b1, "f3_u0_00");
    goto(2, 0);  xp(2, 16'h1111, 1'b1, "f3_u2_20");
    goto(3, 1);  xp(1, 16'h07E0, 1'b1, "f3_u1_31");
    goto(15, 7); fd[2] = 1'b1;
    goto(16, 7);
    for (int d = 0; d < 3; d++) chk_st(d, 1'b1, 1'b0, 1'b0, 1'b1, "f3_swap");

    // Frame 4: bank 0 is front again; u2 old front contents preserved
    goto(0, 0); xp(0, 16'h0000, 1'b1, "f4_u0_00");
    goto(3, 0); xp(2, 16'h2222, 1'b1, "f4_u2_30");
    goto(1, 1); xp(0, 16'h0ABC, 1'b1, "f4_u0_11");
    goto(3, 2); fd[0] = 1'b1; fd[1] = 1'b1;
    goto(16, 7);
    chk_st(0, 1'b0, 1'b0, 1'b1, 1'b0, "f4_u0_wait");

    // Frame 5: armed, swap back to bank 1 at the end
    goto(1, 1); xp(0, 16'h0ABC, 1'b1, "f5_u0_11");
    goto(16, 7);
    chk_st(0, 1'b1, 1'b1, 1'b0, 1'b1, "f5_u0_swap");
    chk_st(1, 1'b1, 1'b1, 1'b0, 1'b1, "f5_u1_swap");

    // Frame 6: bank 1 shows the cleared pixels; then asynchronous reset mid-scan while pending
    goto(0, 0); xp(0, 16'h0000, 1'b1, "f6_u0_cleared");
    goto(1, 0); fd[0] = 1'b1;
    goto(2, 0); xp(1, 16'h0000, 1'b1, "f6_u1_cleared");
    goto(3, 0); xp(2, 16'h2222, 1'b1, "f6_u2_30");
    goto(5, 0);
    chk_st(0, 1'b0, 1'b1, 1'b1, 1'b0, "f6_u0_pend");
    rst_n = 1'b0;
    #1;
    chk_st(0, 1'b0, 1'b0, 1'b0, 1'b1, "arst_u0");
    chk_word("arst_u2_pix", pix[2], 16'h0000);
    chk_bit("arst_u2_vld", pvld[2], 1'b0);
    repeat (2) step();
    chk_word("sb_empty", 16'(sb.size()), 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
